// File: rtl/deser_pkg.sv
// Shared state, lane-select encodings and lane-count decode for the multi-lane deserializer.
// Used by deser_ctrl and deser_multilane; DESER_START_BIT_HUNT_EN selects whether HUNT is reachable.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LANE_SEL_1 = 2'd0;
    localparam logic [1:0] LANE_SEL_2 = 2'd1;
    localparam logic [1:0] LANE_SEL_4 = 2'd2;
    localparam logic [1:0] LANE_SEL_8 = 2'd3;

    // Requests wider than the physical lane count fall back to a single lane.
    function automatic logic [3:0] lanes_of(input logic [1:0] sel, input int unsigned lanes);
        logic [3:0] n;
        case (sel)
            LANE_SEL_1: n = 4'd1;
            LANE_SEL_2: n = 4'd2;
            LANE_SEL_4: n = 4'd4;
            default:    n = 4'd8;
        endcase
        if (32'(n) > lanes) n = 4'd1;
        return n;
    endfunction

endpackage

// File: rtl/deser_ctrl.sv
// Frame controller: FSM, bit counter, latched lane count / frame length and status flags.
// With DESER_START_BIT_HUNT_EN defined, an accepted start waits in HUNT for an all-zero start bit.
module deser_ctrl
    import deser_pkg::*;
#(
    parameter int unsigned BITS         = 136,
    parameter int unsigned BITS_COUNTER = 8,
    parameter int unsigned LANES        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    ack,
    input  logic [1:0]              lane_sel,
    input  logic [BITS_COUNTER-1:0] framesize,
`ifdef DESER_START_BIT_HUNT_EN
    input  logic [LANES-1:0]        in,
`endif
    output logic                    we,
    output logic [BITS_COUNTER-1:0] base,
    output logic [3:0]              lanes,
    output logic [BITS_COUNTER-1:0] limit,
    output logic                    complete,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [BITS_COUNTER-1:0] BITS_C = BITS_COUNTER'(BITS);
`ifdef DESER_START_BIT_HUNT_EN
    localparam state_t FIRST = HUNT;
`else
    localparam state_t FIRST = SHIFT;
`endif

    state_t                  state_q, state_d;
    logic [BITS_COUNTER-1:0] count_q, count_d;
    logic [BITS_COUNTER-1:0] f_q, f_d;
    logic [BITS_COUNTER-1:0] sum;
    logic [3:0]              n_q, n_d;
    logic                    busy_d, complete_d, overrun_d;
    logic                    load;

`ifdef DESER_START_BIT_HUNT_EN
    logic hunt_zero;

    always_comb begin
        hunt_zero = 1'b1;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (j < 32'(n_q) && in[j]) hunt_zero = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        n_d        = n_q;
        f_d        = f_q;
        busy_d     = busy;
        complete_d = complete;
        overrun_d  = overrun;
        we         = 1'b0;
        load       = 1'b0;
        sum        = count_q + BITS_COUNTER'(n_q);

        case (state_q)
            IDLE: load = start && enable;
`ifdef DESER_START_BIT_HUNT_EN
            HUNT: begin
                if (start) overrun_d = 1'b1;
                if (enable && hunt_zero) state_d = SHIFT;
            end
`endif
            SHIFT: begin
                if (start) overrun_d = 1'b1;
                if (enable) begin
                    we      = 1'b1;
                    count_d = sum;
                    if (sum >= f_q) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        complete_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    complete_d = 1'b0;
                    state_d    = IDLE;
                    load       = start && enable;
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load from IDLE or from DONE+ack shares one path so back-to-back frames need no idle cycle.
        if (load) begin
            state_d   = FIRST;
            n_d       = lanes_of(lane_sel, LANES);
            f_d       = (framesize > BITS_C) ? BITS_C : framesize;
            count_d   = '0;
            busy_d    = 1'b1;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            n_q      <= 4'd1;
            f_q      <= '0;
            busy     <= 1'b0;
            complete <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            n_q      <= n_d;
            f_q      <= f_d;
            busy     <= busy_d;
            complete <= complete_d;
            overrun  <= overrun_d;
        end
    end

    assign base  = count_q;
    assign lanes = n_q;
    assign limit = f_q;

endmodule

// File: rtl/deser_multilane.sv
// Multi-lane SD frame deserializer: frame register plus per-lane index decode around deser_ctrl.
// Optional start-bit hunting is enabled by defining DESER_START_BIT_HUNT_EN.
module deser_multilane
    import deser_pkg::*;
#(
    parameter int unsigned BITS         = 136,
    parameter int unsigned BITS_COUNTER = 8,
    parameter int unsigned LANES        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [1:0]              lane_sel,
    input  logic [BITS_COUNTER-1:0] framesize,
    input  logic [LANES-1:0]        in,
    input  logic                    ack,
    output logic [BITS-1:0]         out,
    output logic                    complete,
    output logic                    busy,
    output logic                    overrun
);

    logic                    we;
    logic [BITS_COUNTER-1:0] base;
    logic [BITS_COUNTER-1:0] limit;
    logic [3:0]              lanes;
    logic [BITS-1:0]         out_d;

    deser_ctrl #(
        .BITS         (BITS),
        .BITS_COUNTER (BITS_COUNTER),
        .LANES        (LANES)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .ack       (ack),
        .lane_sel  (lane_sel),
        .framesize (framesize),
`ifdef DESER_START_BIT_HUNT_EN
        .in        (in),
`endif
        .we        (we),
        .base      (base),
        .lanes     (lanes),
        .limit     (limit),
        .complete  (complete),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Bits at or beyond the frame length are never written, so stale data survives between frames.
    always_comb begin
        out_d = out;
        if (we) begin
            for (int unsigned k = 0; k < BITS; k++) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (j < 32'(lanes) &&
                        BITS_COUNTER'(k) == base + BITS_COUNTER'(j) &&
                        BITS_COUNTER'(k) < limit)
                        out_d[k] = in[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out <= '0;
        else        out <= out_d;
    end

endmodule

// File: tb/tb_deser_multilane.sv
// Self-checking bench for deser_multilane: vector table, scoreboard queue and corner-case sequences.
// Expectations follow DESER_START_BIT_HUNT_EN when it is defined for the build.
module tb_deser_multilane;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic [1:0]   lane_sel;
    logic [7:0]   framesize;
    logic [3:0]   in;
    logic         ack;
    logic [135:0] out;
    logic         complete;
    logic         busy;
    logic         overrun;

    int checks   = 0;
    int failures = 0;
    logic [135:0] exp_out;
    logic [135:0] sb[$];

    typedef struct {
        logic [1:0]   sel;
        logic [7:0]   fs;
        int           n;
        int           f_eff;
        logic [135:0] payload;
        int           beats;
    } vec_t;
    vec_t vecs[8];

    deser_multilane #(
        .BITS         (136),
        .BITS_COUNTER (8),
        .LANES        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .lane_sel  (lane_sel),
        .framesize (framesize),
        .in        (in),
        .ack       (ack),
        .out       (out),
        .complete  (complete),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic expect_frame(input int f_eff, input logic [135:0] payload);
        logic [135:0] mask;
        mask = (f_eff >= 136) ? '1 : ((136'(1) << f_eff) - 136'(1));
        exp_out = (exp_out & ~mask) | (payload & mask);
        sb.push_back(exp_out);
    endtask

    task automatic start_frame(input logic [1:0] sel, input logic [7:0] fs);
        lane_sel  = sel;
        framesize = fs;
        enable    = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("start busy", 136'(busy), 136'(1));
        check("start overrun", 136'(overrun), 136'(0));
        lane_sel  = ~sel;
        framesize = 8'($urandom);
    endtask

    // Drives beats until complete; optional 2-cycle enable stall and a refused start mid-frame.
    task automatic run_beats(input int n, input logic [135:0] payload, input int exp_edges,
                             input int start_at, input int stall_at, input string tag);
        int edges = 0;
        int b = 0;
        int stalls = 0;
        int idx;
        logic beat;
        int want;
        logic [135:0] expv;
        want = exp_edges;
`ifdef DESER_START_BIT_HUNT_EN
        in = '0;
        tick();
        edges++;
        want++;
`endif
        while (complete !== 1'b1 && edges < want + 8) begin
            beat = !(b == stall_at && stalls < 2);
            if (!beat) begin
                enable = 1'b0;
                start  = 1'b0;
                stalls++;
                in = 4'($urandom);
            end else begin
                enable = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    idx = b * n + j;
                    if (j < n && idx < 136) in[j] = payload[idx];
                    else                    in[j] = 1'($urandom);
                end
                start = (b == start_at);
                if (start) lane_sel = 2'd2;
            end
            tick();
            edges++;
            if (beat) b++;
        end
        start  = 1'b0;
        enable = 1'b1;
        check({tag, " latency"}, 136'(edges), 136'(want));
        check({tag, " busy"}, 136'(busy), 136'(0));
        check({tag, " complete"}, 136'(complete), 136'(1));
        if (start_at >= 0) check({tag, " overrun"}, 136'(overrun), 136'(1));
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 136'(0), 136'(1));
        end else begin
            expv = sb.pop_front();
            check({tag, " out"}, out, expv);
        end
    endtask

    task automatic finish_frame(input string tag);
        in = 4'($urandom);
        tick();
        check({tag, " hold out"}, out, exp_out);
        check({tag, " hold complete"}, 136'(complete), 136'(1));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, " ack clears"}, 136'(complete), 136'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hs;
        int edges;
        int hunt_edges;
        logic [7:0] hunt_byte;

        vecs[0] = '{2'd0, 8'd48,  1, 48,  {17{8'hA5}},                      48};
        vecs[1] = '{2'd2, 8'd10,  4, 10,  136'hFC3,                         3};
        vecs[2] = '{2'd1, 8'd7,   2, 7,   136'hDA,                          4};
        vecs[3] = '{2'd3, 8'd5,   1, 5,   136'h15,                          5};
        vecs[4] = '{2'd2, 8'd200, 4, 136, {{4{32'hDEADBEEF}}, 8'h3C},       34};
        vecs[5] = '{2'd2, 8'd0,   4, 0,   '1,                               1};
        vecs[6] = '{2'd1, 8'd136, 2, 136, {{4{32'h12345678}}, 8'hE1},       68};
        vecs[7] = '{2'd0, 8'd1,   1, 1,   136'h0,                           1};

        reset = 1'b0; enable = 1'b0; start = 1'b0; ack = 1'b0;
        lane_sel = 2'd0; framesize = 8'd0; in = '0;
        exp_out = '0;
        tick();
        tick();
        check("reset out", out, 136'(0));
        check("reset complete", 136'(complete), 136'(0));
        check("reset busy", 136'(busy), 136'(0));
        check("reset overrun", 136'(overrun), 136'(0));
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].sel, vecs[i].fs);
            expect_frame(vecs[i].f_eff, vecs[i].payload);
            run_beats(vecs[i].n, vecs[i].payload, vecs[i].beats, -1, -1, $sformatf("vec%0d", i));
            finish_frame($sformatf("vec%0d", i));
        end

        start_frame(2'd0, 8'd8);
        expect_frame(8, 136'hB2);
        run_beats(1, 136'hB2, 10, -1, 3, "stall");
        finish_frame("stall");

        start_frame(2'd0, 8'd4);
        expect_frame(4, 136'h9);
        run_beats(1, 136'h9, 4, 2, -1, "ovr");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done refuse overrun", 136'(overrun), 136'(1));
        check("done refuse complete", 136'(complete), 136'(1));
        ack = 1'b1; start = 1'b1; lane_sel = 2'd2; framesize = 8'd8; enable = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        check("b2b complete", 136'(complete), 136'(0));
        check("b2b busy", 136'(busy), 136'(1));
        check("b2b overrun", 136'(overrun), 136'(0));
        expect_frame(8, 136'hA7);
        run_beats(4, 136'hA7, 2, -1, -1, "b2b");
        finish_frame("b2b");

        hs = 32'h365F;
`ifdef DESER_START_BIT_HUNT_EN
        hunt_edges = 14;
        hunt_byte  = 8'hD9;
`else
        hunt_edges = 8;
        hunt_byte  = 8'h5F;
`endif
        start_frame(2'd0, 8'd8);
        expect_frame(8, 136'(hunt_byte));
        edges = 0;
        for (int e = 0; e < 24 && complete !== 1'b1; e++) begin
            in = {3'($urandom), hs[e]};
            tick();
            edges++;
        end
        check("hunt latency", 136'(edges), 136'(hunt_edges));
        check("hunt out", out, sb.size() > 0 ? sb.pop_front() : ~exp_out);
        finish_frame("hunt");

        start_frame(2'd0, 8'd40);
        for (int e = 0; e < 20; e++) begin
            in = 4'($urandom);
            tick();
        end
        #1;
        reset = 1'b0;
        #1;
        check("async reset out", out, 136'(0));
        check("async reset complete", 136'(complete), 136'(0));
        check("async reset busy", 136'(busy), 136'(0));
        #2;
        reset = 1'b1;
        exp_out = '0;
        tick();

        enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        check("idle disabled start busy", 136'(busy), 136'(0));
        check("idle disabled start overrun", 136'(overrun), 136'(0));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle ack complete", 136'(complete), 136'(0));
        check("idle ack busy", 136'(busy), 136'(0));
        check("idle out", out, exp_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
